mem_req_arbiter: RTL and testbench

//  N-to-1 arbiter for the core's generic req/gnt/rvalid memory protocol.

---
 rtl/mem_req_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_req_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_arbiter.sv
// N-to-1 round-robin arbiter for the req/gnt/rvalid memory protocol.
// Granted port IDs are queued so that in-order responses reach the right master.
module mem_req_arbiter #(
    parameter int NUM_PORTS       = 4,
    parameter int ADDRESS_SIZE    = 64,
    parameter int DATA_WIDTH      = 64,
    parameter int MAX_OUTSTANDING = 4,
    localparam int BE_W           = DATA_WIDTH / 8,
    localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NUM_PORTS-1:0]           port_req_i,
    input  logic [NUM_PORTS*ADDRESS_SIZE-1:0] port_address_i,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]   port_wdata_i,
    input  logic [NUM_PORTS-1:0]           port_we_i,
    input  logic [NUM_PORTS*BE_W-1:0]      port_be_i,
    output logic [NUM_PORTS-1:0]           port_gnt_o,
    output logic [NUM_PORTS-1:0]           port_rvalid_o,
    output logic [DATA_WIDTH-1:0]          port_rdata_o,
    output logic                           mem_req_o,
    output logic [ADDRESS_SIZE-1:0]        mem_address_o,
    output logic [DATA_WIDTH-1:0]          mem_wdata_o,
    output logic                           mem_we_o,
    output logic [BE_W-1:0]                mem_be_o,
    input  logic                           mem_gnt_i,
    input  logic                           mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]          mem_rdata_i,
    output logic [CNT_W-1:0]               outstanding_o,
    output logic                           err_o
);

    localparam int IDX_W = $clog2(NUM_PORTS);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             lock_q, lock_d;
    logic [IDX_W-1:0] lock_port_q, lock_port_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             err_q, err_d;
    logic [IDX_W-1:0] fifo_q [MAX_OUTSTANDING];

    logic [IDX_W-1:0] rr_sel, sel, idx, head;
    logic             found, has_req, full, grant, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    // First requester at or after the round-robin pointer; a pending lock overrides it.
    always_comb begin
        found  = 1'b0;
        rr_sel = rr_ptr_q;
        idx    = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx = IDX_W'((int'(rr_ptr_q) + i) % NUM_PORTS);
            if (!found && port_req_i[idx]) begin
                found  = 1'b1;
                rr_sel = idx;
            end
        end
        sel     = lock_q ? lock_port_q : rr_sel;
        has_req = found | lock_q;
        full    = (count_q == CNT_W'(MAX_OUTSTANDING));
        mem_req_o = has_req & ~full & ~rst_i;
        grant   = mem_req_o & mem_gnt_i;
        pop     = mem_rvalid_i & (count_q != '0) & ~rst_i;
        head    = fifo_q[rd_ptr_q];
    end

    always_comb begin
        mem_address_o = '0;
        mem_wdata_o   = '0;
        mem_we_o      = 1'b0;
        mem_be_o      = '0;
        if (mem_req_o) begin
            mem_address_o = port_address_i[sel*ADDRESS_SIZE +: ADDRESS_SIZE];
            mem_wdata_o   = port_wdata_i[sel*DATA_WIDTH +: DATA_WIDTH];
            mem_we_o      = port_we_i[sel];
            mem_be_o      = port_be_i[sel*BE_W +: BE_W];
        end
    end

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
        assign port_gnt_o[gi]    = grant & (sel == IDX_W'(gi));
        assign port_rvalid_o[gi] = pop & (head == IDX_W'(gi));
    end

    assign port_rdata_o  = mem_rdata_i;
    assign outstanding_o = count_q;
    assign err_o         = err_q;

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        lock_d      = lock_q;
        lock_port_d = lock_port_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        err_d       = err_q | (mem_rvalid_i & (count_q == '0));
        if (grant) begin
            rr_ptr_d = (sel == IDX_W'(NUM_PORTS - 1)) ? '0 : sel + 1'b1;
            lock_d   = 1'b0;
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end else if (mem_req_o) begin
            lock_d      = 1'b1;
            lock_port_d = sel;
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({grant, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr_q    <= '0;
            lock_q      <= 1'b0;
            lock_port_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            lock_q      <= lock_d;
            lock_port_q <= lock_port_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            err_q       <= err_d;
        end
    end

    // Storage needs no reset: only slots between the pointers are ever read.
    always_ff @(posedge clk_i) begin
        if (grant) begin
            fifo_q[wr_ptr_q] <= sel;
        end
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Scoreboard bench for mem_req_arbiter: expected grants/responses are queued at
// stimulus time and checked by a negedge monitor; directed checks cover the rest.
module tb_mem_req_arbiter;
    localparam int NP = 4;
    localparam int AS = 64;
    localparam int DW = 64;
    localparam int BW = DW / 8;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic [NP-1:0]   port_req_i;
    logic [NP*AS-1:0] port_address_i;
    logic [NP*DW-1:0] port_wdata_i;
    logic [NP-1:0]   port_we_i;
    logic [NP*BW-1:0] port_be_i;
    logic [NP-1:0]   port_gnt_o, port_rvalid_o;
    logic [DW-1:0]   port_rdata_o;
    logic            mem_req_o;
    logic [AS-1:0]   mem_address_o;
    logic [DW-1:0]   mem_wdata_o;
    logic            mem_we_o;
    logic [BW-1:0]   mem_be_o;
    logic            mem_gnt_i, mem_rvalid_i;
    logic [DW-1:0]   mem_rdata_i;
    logic [2:0]      outstanding_o;
    logic            err_o;

    int total = 0;
    int bad   = 0;
    int gq[$];
    int rq_port[$];
    logic [DW-1:0] rq_data[$];

    mem_req_arbiter dut (
        .clk_i(clk_i), .rst_i(rst_i), .port_req_i(port_req_i),
        .port_address_i(port_address_i), .port_wdata_i(port_wdata_i),
        .port_we_i(port_we_i), .port_be_i(port_be_i), .port_gnt_o(port_gnt_o),
        .port_rvalid_o(port_rvalid_o), .port_rdata_o(port_rdata_o),
        .mem_req_o(mem_req_o), .mem_address_o(mem_address_o),
        .mem_wdata_o(mem_wdata_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i), .outstanding_o(outstanding_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    function automatic logic [63:0] addr_of(input int p);
        return 64'h40 * (p + 1);
    endfunction

    always @(negedge clk_i) begin
        if (port_gnt_o != '0) begin
            if (gq.size() == 0) begin
                total++; bad++;
                $display("FAIL gnt_unexpected: got %b expected none at %0t", port_gnt_o, $time);
            end else begin
                automatic int p = gq.pop_front();
                chk("gnt_port", 64'(port_gnt_o), 64'(1) << p);
                chk("gnt_addr", mem_address_o, addr_of(p));
                chk("gnt_we", 64'(mem_we_o), 64'(p % 2));
                chk("gnt_be", 64'(mem_be_o), 64'h11 * (p + 1));
            end
        end
        if (port_rvalid_o != '0) begin
            if (rq_port.size() == 0) begin
                total++; bad++;
                $display("FAIL rvalid_unexpected: got %b expected none at %0t", port_rvalid_o, $time);
            end else begin
                automatic int p = rq_port.pop_front();
                automatic logic [DW-1:0] d = rq_data.pop_front();
                chk("rvalid_port", 64'(port_rvalid_o), 64'(1) << p);
                chk("rvalid_data", port_rdata_o, d);
            end
        end
    end

    // Inputs change 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        port_req_i = '0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    endtask

    task automatic do_reset();
        idle();
        rst_i = 1'b1;
        step(); step();
        rst_i = 1'b0;
    endtask

    task automatic exp_resp(input int p, input logic [DW-1:0] d);
        rq_port.push_back(p);
        rq_data.push_back(d);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int p = 0; p < NP; p++) begin
            port_address_i[p*AS +: AS] = addr_of(p);
            port_wdata_i[p*DW +: DW]   = 64'h5000 + 64'(p);
            port_we_i[p]               = p[0];
            port_be_i[p*BW +: BW]      = 8'(8'h11 * (p + 1));
        end
        rst_i = 1'b0;
        idle();
        do_reset();
        #3;
        chk("rst_outstanding", 64'(outstanding_o), 0);
        chk("rst_err", 64'(err_o), 0);
        chk("rst_mem_req", 64'(mem_req_o), 0);

        // T1 single read
        step();
        port_req_i = 4'b0010; mem_gnt_i = 1'b1; gq.push_back(1);
        step();
        idle(); mem_rvalid_i = 1'b1; mem_rdata_i = 64'hDEAD; exp_resp(1, 64'hDEAD);
        #3 chk("t1_outstanding", 64'(outstanding_o), 1);
        step();
        idle();
        #3 chk("t1_drained", 64'(outstanding_o), 0);

        // T2 fairness
        do_reset();
        for (int k = 0; k < 7; k++) begin
            port_req_i   = (k < 6) ? 4'b1111 : 4'b0000;
            mem_gnt_i    = (k < 6);
            mem_rvalid_i = (k > 0);
            mem_rdata_i  = 64'h100 + 64'(k);
            if (k < 6) gq.push_back(k % 4);
            if (k > 0) exp_resp((k - 1) % 4, 64'h100 + 64'(k));
            step();
        end
        idle();

        // T3 lock holds port2 while port0 joins
        do_reset();
        for (int k = 0; k < 3; k++) begin
            port_req_i = (k == 0) ? 4'b0100 : 4'b0101;
            mem_gnt_i  = 1'b0;
            #3 chk("t3_locked_addr", mem_address_o, addr_of(2));
            step();
        end
        port_req_i = 4'b0101; mem_gnt_i = 1'b1; gq.push_back(2);
        step();
        port_req_i = 4'b0001; gq.push_back(0);
        step();
        idle(); mem_rvalid_i = 1'b1; mem_rdata_i = 64'h3A; exp_resp(2, 64'h3A);
        step();
        mem_rdata_i = 64'h3B; exp_resp(0, 64'h3B);
        step();
        idle();

        // T4 FIFO full, no same-cycle bypass
        do_reset();
        port_req_i = 4'b0001; mem_gnt_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            gq.push_back(0);
            step();
        end
        #3 chk("t4_full_req", 64'(mem_req_o), 0);
        chk("t4_full_cnt", 64'(outstanding_o), 4);
        step();
        mem_rvalid_i = 1'b1; mem_rdata_i = 64'h41; exp_resp(0, 64'h41);
        #3 chk("t4_no_bypass", 64'(mem_req_o), 0);
        step();
        mem_rvalid_i = 1'b0; gq.push_back(0);
        #3 chk("t4_after_pop_req", 64'(mem_req_o), 1);
        chk("t4_after_pop_cnt", 64'(outstanding_o), 3);
        step();
        idle(); mem_rvalid_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            mem_rdata_i = 64'h50 + 64'(k); exp_resp(0, 64'h50 + 64'(k));
            step();
        end
        idle();

        // T5 routing port3 then port0
        do_reset();
        port_req_i = 4'b1000; mem_gnt_i = 1'b1; gq.push_back(3);
        step();
        port_req_i = 4'b0001; gq.push_back(0);
        step();
        idle(); mem_rvalid_i = 1'b1; mem_rdata_i = 64'hAAAA; exp_resp(3, 64'hAAAA);
        step();
        mem_rdata_i = 64'hBBBB; exp_resp(0, 64'hBBBB);
        step();
        idle();
        #3 chk("t5_drained", 64'(outstanding_o), 0);
        chk("t5_err_clear", 64'(err_o), 0);

        // T6 stray rvalid, sticky error, async reset with outstanding work
        step();
        mem_rvalid_i = 1'b1; mem_rdata_i = 64'hBAD;
        step();
        idle();
        #3 chk("t6_err_set", 64'(err_o), 1);
        step();
        port_req_i = 4'b0001; mem_gnt_i = 1'b1; gq.push_back(0);
        step();
        gq.push_back(0);
        step();
        port_req_i = 4'b0001; mem_gnt_i = 1'b0;
        #2 chk("t6_err_sticky", 64'(err_o), 1);
        chk("t6_outstanding", 64'(outstanding_o), 2);
        rst_i = 1'b1;
        #1 chk("t6_rst_cnt", 64'(outstanding_o), 0);
        chk("t6_rst_err", 64'(err_o), 0);
        chk("t6_rst_req", 64'(mem_req_o), 0);
        step();
        rst_i = 1'b0; idle();
        step(); step();

        chk("end_gnt_queue", 64'(gq.size()), 0);
        chk("end_resp_queue", 64'(rq_port.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
